// File: rtl/simple_and_pkg.sv
// rtl/simple_and_pkg.sv - shared defaults and helpers for the simple_and slice
//
// Purpose: default parameter values and the saturation-value helper used by
//          sat_counter.
package simple_and_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // All-ones value of a cnt_w-bit counter, returned in 32 bits so callers
    // can cast down to their own width.
    function automatic logic [31:0] sat_max(input int cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/simple_and_if.sv
// rtl/simple_and_if.sv - operand/result bundle for the simple_and gate
//
// Purpose: groups the operand inputs and the AND results into one bundle.
// Signals: in_a, in_b    operands (WIDTH bits)
//          out_c         combinational in_a & in_b
//          out_c_q       out_c registered one cycle
//          all_ones      reduction AND of out_c
// Modports: master drives operands and observes results; slave is the gate.
interface simple_and_if
    import simple_and_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_c_q;
    logic             all_ones;

    modport master (
        output in_a,
        output in_b,
        input  out_c,
        input  out_c_q,
        input  all_ones
    );

    modport slave (
        input  in_a,
        input  in_b,
        output out_c,
        output out_c_q,
        output all_ones
    );

endinterface

// File: rtl/simple_and_sat_counter.sv
// rtl/simple_and_sat_counter.sv - clear-priority saturating up-counter
//
// Purpose: counts cycles with inc high, sticks at all-ones, clr wins over inc.
// Ports: clk    rising-edge clock
//        rst_n  asynchronous active-low reset (count -> 0)
//        clr    synchronous clear, highest priority
//        inc    increment request
//        count  current count (CNT_W bits)
module sat_counter
    import simple_and_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(sat_max(CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/simple_and.sv
// rtl/simple_and.sv - bitwise AND with registered copy and all-ones counter
//
// Purpose: out_c = in_a & in_b with zero latency, a one-cycle registered copy,
//          a reduction-AND flag and a saturating count of all-ones cycles.
// Ports: clk        rising-edge clock
//        rst_n      asynchronous active-low reset for registered outputs
//        clr_count  synchronous clear of hi_count (beats increment)
//        bus        simple_and_if slave: in_a, in_b, out_c, out_c_q, all_ones
//        hi_count   saturating count of edges sampled with all_ones=1
//        rise_pulse one-cycle pulse on a 0->1 change of registered all_ones
//                   (present only when SIMPLE_AND_RISE_PULSE_EN is defined)
module simple_and
    import simple_and_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_count,
    simple_and_if.slave      bus,
    output logic [CNT_W-1:0] hi_count
`ifdef SIMPLE_AND_RISE_PULSE_EN
    ,
    output logic             rise_pulse
`endif
);

    // Primary path: purely combinational, untouched by clk or rst_n.
    assign bus.out_c    = bus.in_a & bus.in_b;
    assign bus.all_ones = &bus.out_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_c_q <= '0;
        end else begin
            bus.out_c_q <= bus.out_c;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hi_count (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_count),
        .inc   (bus.all_ones),
        .count (hi_count)
    );

`ifdef SIMPLE_AND_RISE_PULSE_EN
    // all_ones_prev resets to 0 so a flag already high at the first
    // post-reset edge still counts as a rising edge.
    logic all_ones_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ones_prev <= 1'b0;
            rise_pulse    <= 1'b0;
        end else begin
            all_ones_prev <= bus.all_ones;
            rise_pulse    <= bus.all_ones & ~all_ones_prev;
        end
    end
`endif

endmodule

// File: tb/tb_simple_and.sv
// tb/tb_simple_and.sv - directed self-checking bench for simple_and
module tb_simple_and;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;
    logic clr1   = 1'b0;
    logic clr4   = 1'b0;
    logic [1:0]  hi1;
    logic [15:0] hi4;
`ifdef SIMPLE_AND_RISE_PULSE_EN
    logic rp1;
    logic rp4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 if (clk_en) clk = ~clk;

    simple_and_if #(.WIDTH(1)) if1 ();
    simple_and_if #(.WIDTH(4)) if4 ();

    simple_and #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_count  (clr1),
        .bus        (if1),
        .hi_count   (hi1)
`ifdef SIMPLE_AND_RISE_PULSE_EN
        ,
        .rise_pulse (rp1)
`endif
    );

    simple_and #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_count  (clr4),
        .bus        (if4),
        .hi_count   (hi4)
`ifdef SIMPLE_AND_RISE_PULSE_EN
        ,
        .rise_pulse (rp4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tt_a [5];
        logic [1:0] tt_b [5];
        logic       tt_c [5];
        logic [1:0] sat_exp [6];
        tt_a = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt_b = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tt_c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        if1.in_a = 1'b0; if1.in_b = 1'b0;
        if4.in_a = 4'h0; if4.in_b = 4'h0;
        #1;
        check("reset_q1",  if1.out_c_q, 64'd0);
        check("reset_hi1", hi1, 64'd0);
        check("reset_q4",  if4.out_c_q, 64'd0);
        check("reset_hi4", hi4, 64'd0);

        // Truth table, no clock, reset held: out_c is independent of both.
        for (int i = 0; i < 5; i++) begin
            #10;
            if1.in_a = tt_a[i][0];
            if1.in_b = tt_b[i][0];
            #1;
            check($sformatf("tt_out_c_%0d", i), if1.out_c, 64'(tt_c[i]));
            check($sformatf("tt_all1_%0d", i), if1.all_ones, 64'(tt_c[i]));
        end

        rst_n  = 1'b1;
        clk_en = 1'b1;
        step();
        check("q_idle", if1.out_c_q, 64'd0);

        // Registered path: visible only after the next edge.
        if1.in_a = 1'b1; if1.in_b = 1'b1;
        #1;
        check("q_before_edge", if1.out_c_q, 64'd0);
        check("c_now", if1.out_c, 64'd1);
        step();
        check("q_after_edge_n", if1.out_c_q, 64'd1);
        check("hi1_first", hi1, 64'd1);
        if1.in_a = 1'b0;
        step();
        check("q_after_edge_n1", if1.out_c_q, 64'd0);
        check("hi1_hold", hi1, 64'd1);

        clr1 = 1'b1;
        step();
        clr1 = 1'b0;
        check("hi1_cleared", hi1, 64'd0);

        // Saturation with CNT_W=2.
        if1.in_a = 1'b1; if1.in_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sat_%0d", i), hi1, 64'(sat_exp[i]));
        end

        // Clear beats increment.
        clr1 = 1'b1;
        step();
        check("clr_priority", hi1, 64'd0);
        clr1 = 1'b0;
        step();
        check("after_clr", hi1, 64'd1);

        // WIDTH=4 patterns.
        if4.in_a = 4'b1011; if4.in_b = 4'b1110;
        #1;
        check("w4_out_c", if4.out_c, 64'hA);
        check("w4_all1_0", if4.all_ones, 64'd0);
        step();
        check("w4_q", if4.out_c_q, 64'hA);
        check("w4_hi_0", hi4, 64'd0);
`ifdef SIMPLE_AND_RISE_PULSE_EN
        check("rp_idle", rp4, 64'd0);
`endif
        if4.in_a = 4'hF; if4.in_b = 4'hF;
        #1;
        check("w4_all1_1", if4.all_ones, 64'd1);
        step();
        check("w4_hi_1", hi4, 64'd1);
`ifdef SIMPLE_AND_RISE_PULSE_EN
        check("rp_high", rp4, 64'd1);
`endif
        step();
        check("w4_hi_2", hi4, 64'd2);
`ifdef SIMPLE_AND_RISE_PULSE_EN
        check("rp_one_cycle", rp4, 64'd0);
`endif
        step(); step(); step();
        check("w4_hi_5", hi4, 64'd5);
        check("w4_q_f", if4.out_c_q, 64'hF);

        // Async reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q4", if4.out_c_q, 64'd0);
        check("arst_hi4", hi4, 64'd0);
        check("arst_q1", if1.out_c_q, 64'd0);
        check("arst_c4", if4.out_c, 64'hF);
        if4.in_a = 4'b0110;
        #1;
        check("arst_c4_track", if4.out_c, 64'h6);
        if4.in_a = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel_q4", if4.out_c_q, 64'hF);
        check("rel_hi4", hi4, 64'd1);
        check("rel_hi1", hi1, 64'd1);
`ifdef SIMPLE_AND_RISE_PULSE_EN
        check("rel_rp4", rp4, 64'd1);
        check("rel_rp1", rp1, 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_and.md
Name: simple_and

Overview:
- Bitwise 2-input AND gate with a registered copy of the result and a saturating "all-ones" cycle counter.
- Leaf utility for glue logic and enable qualification.
- Combinational path is the primary function: out_c follows inputs with zero latency, independent of clock and reset.
- Registered and statistics outputs support timing closure and debug observability.

Parameters:
- WIDTH, 1, bit width of in_a, in_b, out_c, out_c_q (legal range 1..64).
- CNT_W, 16, width of hi_count (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock for registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- clr_count  input  1  synchronous clear of hi_count.
- out_c  output  WIDTH  combinational in_a & in_b.
- out_c_q  output  WIDTH  out_c registered one cycle.
- all_ones  output  1  combinational reduction AND of out_c.
- hi_count  output  CNT_W  saturating count of clock edges sampled with all_ones=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- out_c = in_a & in_b, bitwise, purely combinational.
  - Valid in the same time step as any input change.
  - Unaffected by rst_n or clk.
- Truth table per bit: 00→0, 01→0, 10→0, 11→1.
- X/Z on an input bit propagates per standard 4-state AND. A 0 on either input forces 0.
- all_ones = &out_c, combinational. For WIDTH=1, all_ones equals out_c.
- out_c_q:
  - rst_n low → 0 immediately, asynchronously.
  - Otherwise loads out_c on each rising clk. Latency is 1 cycle.
- hi_count:
  - rst_n low → 0 immediately.
  - On each rising clk with rst_n high:
    - clr_count=1 → 0. Clear has priority over increment, including when all_ones=1 in the same cycle.
    - Else if all_ones=1 and hi_count < 2^CNT_W−1 → increment by 1.
    - Else hold.
  - Saturates at all-ones; never wraps.
- Reset mid-operation: registered outputs clear within the same time step as rst_n falling. out_c continues to track inputs.
- Reset release: first capture on the first rising clk after rst_n rises. No synchroniser inside the block; the system provides reset-deassertion synchronisation.

Optional Feature:
- SIMPLE_AND_RISE_PULSE_EN.
- Defined:
  - Adds output rise_pulse (1 bit), high for exactly one cycle after a rising clk where all_ones=1 and the previously registered all_ones was 0.
  - Previous-value register resets to 0, so all_ones already 1 at the first post-reset edge produces a pulse.
  - rise_pulse resets to 0 asynchronously.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package simple_and_pkg holds:
  - localparam defaults: DEF_WIDTH=1, DEF_CNT_W=16.
  - Function sat_max(CNT_W) returning the all-ones saturation value.
- One sub-module: sat_counter.
  - Parameterised CNT_W.
  - Inputs clk, rst_n, clr, inc; output count.
  - Clear-priority saturating up-counter.
  - Instantiated once for hi_count.
- AND logic and out_c_q register stay in simple_and.

Test Plan:
- Truth table, WIDTH=1, no clock activity: in_a/in_b = 0/0, 0/1, 1/0, 1/1, 0/0 at 10 ns steps → out_c = 0, 0, 0, 1, 0 in the same time step as each change.
- Registered path: apply 1/1 before edge N → out_c_q=1 after edge N, not before. Drop to 0/1 → out_c_q=0 after edge N+1.
- Async reset mid-run: out_c_q=1, hi_count=5, assert rst_n=0 between edges → both 0 immediately. out_c still equals in_a&in_b.
- Counter saturation: CNT_W=2, hold all_ones=1 for 6 edges → hi_count 1, 2, 3, 3, 3, 3.
- Clear priority: hi_count=3, clr_count=1 and all_ones=1 on the same edge → hi_count=0. Next edge with clr_count=0 → 1.
- WIDTH=4: in_a=4'b1011, in_b=4'b1110 → out_c=4'b1010, all_ones=0. in_a=in_b=4'hF → all_ones=1. With SIMPLE_AND_RISE_PULSE_EN defined, rise_pulse high for exactly one cycle.
